// File: rtl/bus_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_port
// Function : Slave endpoint of the 2-master / 3-slave bus. It accepts edge-
//            triggered read and write commands and runs them against a local
//            word memory with a programmable number of wait states. Reads
//            return through a valid/ready handshake.
//            Optional feature: define BUS_SLAVE_ERR_EN to flag accesses at or
//            above MEM_DEPTH as errors instead of wrapping the address.
// Revision : 1.0  initial release
// ============================================================================
module bus_slave_port #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_slave,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              wr_done,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic              err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LIM_W = ADDR_W + 1;
    localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wen_prev_q, ren_prev_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              wr_done_q, wr_done_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              wen_edge;
    logic              ren_edge;
    logic              is_idle;
    logic              mem_we;
    logic              addr_oor;
    logic              access_err;
    logic [1:0]        num_drops;
    logic [8:0]        drop_sum;

    assign wen_edge = wen & ~wen_prev_q;
    assign ren_edge = ren & ~ren_prev_q;
    assign is_idle  = (state_q == ST_IDLE);
    assign addr_oor = ({1'b0, address_slave} >= DEPTH_LIM);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        wr_done_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Write has priority; a coincident read edge is counted as a drop.
                if (wen_edge) begin
                    idx_d   = address_slave[IDX_W-1:0];
                    wdata_d = data;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_WR_WAIT;
                end else if (ren_edge) begin
                    idx_d   = address_slave[IDX_W-1:0];
                    cnt_d   = WAIT_INIT;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we    = ~access_err;
                    wr_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d  = access_err ? '0 : mem[idx_q];
                    rvalid_d = 1'b1;
                    state_d  = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every edge seen while busy is lost; in IDLE only the read of a
    // simultaneous write/read pair is lost.
    always_comb begin
        num_drops = '0;
        if (is_idle) begin
            num_drops = {1'b0, wen_edge & ren_edge};
        end else begin
            num_drops = {1'b0, wen_edge} + {1'b0, ren_edge};
        end
        drop_sum   = {1'b0, drop_cnt_q} + {7'd0, num_drops};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wen_prev_q <= 1'b0;
            ren_prev_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wen_prev_q <= wen;
            ren_prev_q <= ren;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wr_done_q  <= wr_done_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Memory contents survive reset; state_q drops to IDLE asynchronously,
    // which removes any pending write enable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef BUS_SLAVE_ERR_EN
    logic oor_q, oor_d;
    logic err_q, err_d;

    always_comb begin
        oor_d = oor_q;
        err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wen_edge || ren_edge) begin
                    oor_d = addr_oor;
                end
            end
            ST_WR_WAIT: err_d = (cnt_q == 4'd0) & oor_q;
            ST_RD_WAIT: err_d = (cnt_q == 4'd0) & oor_q;
            ST_RD_RESP: err_d = err_q & ~rready;
            default:    err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            oor_q <= oor_d;
            err_q <= err_d;
        end
    end

    assign access_err = oor_q;
    assign err        = err_q;
`else
    logic unused_addr_oor;

    assign unused_addr_oor = addr_oor;
    assign access_err      = 1'b0;
    assign err             = 1'b0;
`endif

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign wr_done  = wr_done_q;
    assign busy     = ~is_idle;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_port
// Function : Self-checking bench for bus_slave_port: directed scenarios plus
//            randomized reads/writes against a behavioural memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_slave_port;

    localparam int WS    = 2;
    localparam int DEPTH = 4096;
`ifdef BUS_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [12:0] address_slave;
    logic [31:0] data;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        wr_done;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        err;

    int          errors;
    int          checks;
    int          drop_exp;
    logic [31:0] ref_mem [int];
    logic [12:0] written [$];

    bus_slave_port #(
        .ADDR_W      (13),
        .DATA_W      (32),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .address_slave (address_slave),
        .data          (data),
        .wen           (wen),
        .ren           (ren),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .rready        (rready),
        .wr_done       (wr_done),
        .busy          (busy),
        .drop_cnt      (drop_cnt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drop_bump(input int n);
        for (int i = 0; i < n; i++) begin
            if (drop_exp < 255) drop_exp++;
        end
    endtask

    function automatic bit is_oor(input logic [12:0] a);
        return ERR_EN && (int'(a) >= DEPTH);
    endfunction

    function automatic int key_of(input logic [12:0] a);
        return int'(a) % DEPTH;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [12:0] a);
        if (is_oor(a)) return 32'h0;
        return ref_mem[key_of(a)];
    endfunction

    // Write with optional extra held-strobe cycles, a simultaneous read edge,
    // or a read edge arriving on the commit edge.
    task automatic do_write(input logic [12:0] a, input logic [31:0] d,
                            input int hold_extra, input bit with_ren, input bit late_ren);
        address_slave = a;
        data          = d;
        wen           = 1'b1;
        if (with_ren) ren = 1'b1;
        tick();
        chk("wr_busy", busy, 1);
        if (with_ren) begin
            drop_bump(1);
            ren = 1'b0;
        end
        for (int i = 0; i < WS; i++) begin
            tick();
            chk("wr_wait_nodone", wr_done, 0);
        end
        if (late_ren) ren = 1'b1;
        tick();
        chk("wr_done_pulse", wr_done, 1);
        chk("wr_err", err, is_oor(a));
        chk("wr_idle", busy, 0);
        if (late_ren) drop_bump(1);
        if (!is_oor(a)) ref_mem[key_of(a)] = d;
        written.push_back(a);
        for (int i = 0; i < hold_extra; i++) begin
            tick();
            chk("wr_held_nodone", wr_done, 0);
        end
        wen = 1'b0;
        ren = 1'b0;
        tick();
        chk("wr_done_end", wr_done, 0);
        chk("wr_idle_end", busy, 0);
        chk("wr_drops", drop_cnt, drop_exp);
    endtask

    // Read with hold cycles of backpressure and n_inj ren edges during RD_RESP.
    task automatic do_read(input logic [12:0] a, input int hold, input int n_inj);
        logic [31:0] e;
        e = exp_rd(a);
        address_slave = a;
        ren = 1'b1;
        tick();
        chk("rd_busy", busy, 1);
        ren = 1'b0;
        for (int i = 0; i < WS; i++) begin
            tick();
            chk("rd_wait_novalid", rvalid, 0);
        end
        tick();
        chk("rd_valid", rvalid, 1);
        chk("rd_data", rdata, e);
        chk("rd_err", err, is_oor(a));
        for (int i = 0; i < hold; i++) begin
            ren = ((i % 2) == 0) && ((i / 2) < n_inj);
            tick();
            if (ren) drop_bump(1);
            chk("bp_valid", rvalid, 1);
            chk("bp_data", rdata, e);
            chk("bp_busy", busy, 1);
            chk("bp_err", err, is_oor(a));
        end
        ren    = 1'b0;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("hs_valid_clr", rvalid, 0);
        chk("hs_idle", busy, 0);
        chk("hs_data_kept", rdata, e);
        chk("hs_err_clr", err, 0);
        chk("rd_drops", drop_cnt, drop_exp);
    endtask

    initial begin
        logic [12:0] a;
        logic [31:0] d;
        errors        = 0;
        checks        = 0;
        drop_exp      = 0;
        rst           = 1'b1;
        address_slave = '0;
        data          = '0;
        wen           = 1'b0;
        ren           = 1'b0;
        rready        = 1'b0;
        #2;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_write(13'h005, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        do_read(13'h005, 0, 0);

        // wen held high for about ten cycles
        do_write(13'h006, 32'h00000001, 6, 1'b0, 1'b0);
        chk("held_drop_zero", drop_cnt, 0);

        do_read(13'h005, 5, 1);
        chk("bp_drop_one", drop_cnt, 1);

        do_write(13'h007, 32'h00000077, 0, 1'b1, 1'b0);
        do_write(13'h008, 32'h00000088, 0, 1'b0, 1'b1);
        do_read(13'h007, 0, 0);

        do_write(13'h1005, 32'hA5A5A5A5, 0, 1'b0, 1'b0);
        do_read(13'h005, 0, 0);
        do_read(13'h1005, 1, 0);

        // Reset in the middle of a pending write
        do_write(13'h010, 32'h11112222, 0, 1'b0, 1'b0);
        address_slave = 13'h010;
        data          = 32'h12345678;
        wen           = 1'b1;
        tick();
        wen = 1'b0;
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        drop_exp = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_done", wr_done, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_err", err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_nodone", wr_done, 0);
        do_read(13'h010, 0, 0);

        for (int k = 0; k < 40; k++) begin
            if (($urandom_range(0, 2) == 0) || (written.size() == 0)) begin
                a = 13'($urandom);
                d = $urandom;
                do_write(a, d, $urandom_range(0, 2), 1'b0, 1'b0);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                if ($urandom_range(0, 3) == 0) a[12] = ~a[12];
                if (!is_oor(a) && !ref_mem.exists(key_of(a))) begin
                    d = $urandom;
                    do_write(a, d, 0, 1'b0, 1'b0);
                end else begin
                    do_read(a, $urandom_range(0, 4), $urandom_range(0, 2));
                end
            end
        end

        // 300 read edges while the response is held off
        do_read(13'h005, 600, 300);
        chk("drop_saturated", drop_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
